// File: rtl/vga_timing_controller.sv
// Raster timing generator for VGA 640x400@70Hz: horizontal/vertical counters,
// sync and display decodes, one-cycle-early pixel fetch, and a frame-aligned run/stop.
module vga_timing_controller #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 400,
   parameter int unsigned V_FP      = 12,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 35,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   output logic [9:0] h_count,
   output logic [8:0] v_count,
   output logic       hsync,
   output logic       vsync,
   output logic       display_en,
   output logic       fetch_req,
   output logic       line_end,
   output logic       frame_start,
   output logic       busy
);

   localparam int unsigned HW      = 10;
   localparam int unsigned VW      = 9;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [HW-1:0]  h_q, h_d, h_nxt;
   logic [VW-1:0]  v_q, v_d, v_nxt;
   logic           h_wrap, v_wrap;

   // Next-state and next-position; STOP only returns to IDLE on the last pixel of a frame.
   always_comb begin
      h_wrap  = (h_q == H_LAST);
      v_wrap  = (v_q == V_LAST);
      h_nxt   = h_wrap ? '0 : h_q + HW'(1);
      v_nxt   = v_q;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : v_q + VW'(1);
      end
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_RUN;
         end
         ST_RUN: begin
            h_d = h_nxt;
            v_d = v_nxt;
            if (!run) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (h_wrap && v_wrap && !run) begin
               state_d = ST_IDLE;
               h_d     = '0;
               v_d     = '0;
            end else begin
               h_d = h_nxt;
               v_d = v_nxt;
               if (run) state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         h_q     <= '0;
         v_q     <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   // Decodes track the registered counters in the same cycle and go inactive in IDLE.
   always_comb begin
      busy        = (state_q != ST_IDLE);
      h_count     = h_q;
      v_count     = v_q;
      hsync       = (busy && (h_q >= H_SYNC_BEG) && (h_q <= H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync       = (busy && (v_q >= V_SYNC_BEG) && (v_q <= V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
      display_en  = busy && (h_q < H_VIS) && (v_q < V_VIS);
      line_end    = busy && h_wrap;
      frame_start = busy && (h_q == '0) && (v_q == '0);
      // Fetch looks at where the raster will be after the coming edge.
      fetch_req   = !reset && (state_d != ST_IDLE) && (h_d < H_VIS) && (v_d < V_VIS);
   end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a default-timing instance and a scaled-down instance
// share clk/reset/run and are compared every cycle against a frame-position model.
module tb_vga_timing_controller;

   localparam int SH_A = 16, SH_F = 4, SH_S = 6, SH_B = 6;
   localparam int SV_A = 10, SV_F = 2, SV_S = 2, SV_B = 3;
   localparam int S_HT = SH_A + SH_F + SH_S + SH_B;
   localparam int S_VT = SV_A + SV_F + SV_S + SV_B;

   int c_ha[2] = '{640, SH_A};
   int c_hf[2] = '{16,  SH_F};
   int c_hs[2] = '{96,  SH_S};
   int c_hb[2] = '{48,  SH_B};
   int c_va[2] = '{400, SV_A};
   int c_vf[2] = '{12,  SV_F};
   int c_vs[2] = '{2,   SV_S};
   int c_vb[2] = '{35,  SV_B};

   logic clk = 1'b0;
   logic reset;
   logic run;
   logic [9:0] h_w[2];
   logic [8:0] v_w[2];
   logic hs_w[2], vs_w[2], de_w[2], fr_w[2], le_w[2], fs_w[2], bz_w[2];

   always #5 clk = ~clk;

   vga_timing_controller u_def (
      .clk(clk), .reset(reset), .run(run),
      .h_count(h_w[0]), .v_count(v_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
      .display_en(de_w[0]), .fetch_req(fr_w[0]), .line_end(le_w[0]),
      .frame_start(fs_w[0]), .busy(bz_w[0])
   );

   vga_timing_controller #(
      .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
      .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
   ) u_small (
      .clk(clk), .reset(reset), .run(run),
      .h_count(h_w[1]), .v_count(v_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
      .display_en(de_w[1]), .fetch_req(fr_w[1]), .line_end(le_w[1]),
      .frame_start(fs_w[1]), .busy(bz_w[1])
   );

   int passed = 0, total = 0, cyc = 0;
   bit m_act[2];
   int m_pos[2];
   bit m_lrun[2];
   bit meas = 1'b0;
   int last_fs = -1;
   int de_cnt, le_cnt, hs_cnt, vs_cnt;

   function automatic int htot(input int i);
      return c_ha[i] + c_hf[i] + c_hs[i] + c_hb[i];
   endfunction

   function automatic int ftot(input int i);
      return htot(i) * (c_va[i] + c_vf[i] + c_vs[i] + c_vb[i]);
   endfunction

   function automatic bit visible(input int i, input bit act, input int pos);
      return act && ((pos % htot(i)) < c_ha[i]) && ((pos / htot(i)) < c_va[i]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Model: a scan position within the frame; the scan quits only when the last pixel
   // is reached with run low now and at the previous edge.
   task automatic model_next(input int i, input bit r, output bit na, output int np);
      if (!m_act[i]) begin
         na = r;
         np = 0;
      end else if (m_pos[i] == ftot(i) - 1 && !r && !m_lrun[i]) begin
         na = 1'b0;
         np = 0;
      end else begin
         na = 1'b1;
         np = (m_pos[i] + 1) % ftot(i);
      end
   endtask

   task automatic check_inst(input int i, input bit r, input bit rst);
      bit a, na;
      int h, v, np, hb, vb;
      a  = m_act[i];
      h  = m_pos[i] % htot(i);
      v  = m_pos[i] / htot(i);
      hb = c_ha[i] + c_hf[i];
      vb = c_va[i] + c_vf[i];
      chk($sformatf("i%0d.h_count", i), 32'(h_w[i]), 32'(h));
      chk($sformatf("i%0d.v_count", i), 32'(v_w[i]), 32'(v));
      chk($sformatf("i%0d.busy", i), 32'(bz_w[i]), 32'(a));
      chk($sformatf("i%0d.hsync", i), 32'(hs_w[i]), (a && h >= hb && h < hb + c_hs[i]) ? 32'd0 : 32'd1);
      chk($sformatf("i%0d.vsync", i), 32'(vs_w[i]), (a && v >= vb && v < vb + c_vs[i]) ? 32'd1 : 32'd0);
      chk($sformatf("i%0d.display_en", i), 32'(de_w[i]), 32'(visible(i, a, m_pos[i])));
      chk($sformatf("i%0d.line_end", i), 32'(le_w[i]), 32'(a && h == htot(i) - 1));
      chk($sformatf("i%0d.frame_start", i), 32'(fs_w[i]), 32'(a && m_pos[i] == 0));
      model_next(i, r, na, np);
      chk($sformatf("i%0d.fetch_req", i), 32'(fr_w[i]), rst ? 32'd0 : 32'(visible(i, na, np)));
   endtask

   // Frame-level tallies on the scaled instance, checked at each frame_start.
   task automatic frame_stats();
      if (fs_w[1] === 1'b1) begin
         if (last_fs >= 0) begin
            chk("frame_period", 32'(cyc - last_fs), 32'(S_HT * S_VT));
            chk("frame_de_count", 32'(de_cnt), 32'(SH_A * SV_A));
            chk("frame_line_ends", 32'(le_cnt), 32'(S_VT));
            chk("frame_hsync_cycles", 32'(hs_cnt), 32'(SH_S * S_VT));
            chk("frame_vsync_cycles", 32'(vs_cnt), 32'(SV_S * S_HT));
         end
         last_fs = cyc;
         de_cnt = 0; le_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      end
      de_cnt += int'(de_w[1]);
      le_cnt += int'(le_w[1]);
      hs_cnt += int'(!hs_w[1]);
      vs_cnt += int'(vs_w[1]);
   endtask

   task automatic step(input bit r, input bit rst);
      bit na;
      int np;
      @(negedge clk);
      reset = rst;
      run   = r;
      #1;
      for (int i = 0; i < 2; i++) check_inst(i, r, rst);
      if (meas) frame_stats();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i] = 1'b0; m_pos[i] = 0; m_lrun[i] = 1'b0;
         end else begin
            model_next(i, r, na, np);
            m_act[i] = na; m_pos[i] = np; m_lrun[i] = r;
         end
      end
      cyc++;
   endtask

   // Reset asserted between clock edges; outputs must follow without a clock.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_pos[i] = 0; m_lrun[i] = 1'b0;
      end
      for (int i = 0; i < 2; i++) check_inst(i, run, 1'b1);
   endtask

   task automatic wait_at(input bit r, input int hh, input int vv, input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < budget && !hit; n++) begin
         step(r, 1'b0);
         hit = (h_w[1] == 10'(hh)) && (v_w[1] == 9'(vv));
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      bit r;
      int n;
      reset = 1'b1;
      run   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_pos[i] = 0; m_lrun[i] = 1'b0;
      end

      repeat (3) step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);

      // Continuous scan from IDLE.
      meas = 1'b1; last_fs = -1;
      repeat (3 * S_HT * S_VT + 10) step(1'b1, 1'b0);
      meas = 1'b0;

      // Drop run mid-frame; scan must finish the frame then idle.
      wait_at(1'b1, 0, 3, 2 * S_HT * S_VT, "reach_v3_a");
      n = 0;
      while (n < 2 * S_HT * S_VT && bz_w[1] === 1'b1) begin
         step(1'b0, 1'b0);
         n++;
      end
      chk("stop_reaches_idle", 32'(bz_w[1]), 32'd0);
      repeat (3) step(1'b0, 1'b0);

      // Drop then re-raise inside the same frame: no idle, period unchanged.
      meas = 1'b1; last_fs = -1;
      wait_at(1'b1, 0, 3, 2 * S_HT * S_VT, "reach_v3_b");
      wait_at(1'b0, 0, 8, 2 * S_HT * S_VT, "reach_v8");
      repeat (2 * S_HT * S_VT + 20) step(1'b1, 1'b0);
      meas = 1'b0;

      // Mid-frame asynchronous reset, then a fresh frame.
      wait_at(1'b1, 10, 5, 2 * S_HT * S_VT, "reach_mid");
      async_reset();
      repeat (2) step(1'b1, 1'b1);
      repeat (S_HT * S_VT + 40) step(1'b1, 1'b0);

      // Randomized run/stop segments with occasional resets.
      repeat (40) begin
         r = 1'($urandom % 2);
         n = $urandom_range(1, 500);
         repeat (n) step(r, 1'b0);
         if ($urandom % 8 == 0) begin
            async_reset();
            step(r, 1'b1);
         end
      end
      repeat (4) step(1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule
